dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between the core load/store path and a DMA/debug requester.

---
 rtl/dmem_arb_pkg.sv | 29 ++
 rtl/dmem_starve_ctr.sv | 40 ++++
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Holds the FSM/grant encodings and the starvation-counter arithmetic.
package dmem_arb_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        ST_NORMAL,
        ST_FORCE
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CORE,
        GNT_DMA
    } grant_t;

    // Increment that never passes the limit, so the counter parks at MAX_WAIT.
    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] value,
        input logic [CNT_W-1:0] limit
    );
        if (value >= limit) begin
            return limit;
        end
        return value + 4'd1;
    endfunction

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating count of consecutive cycles the DMA requester lost arbitration.
// sat_next_o flags that the value being loaded this cycle has reached the limit.
module dmem_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_next_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over increment: a granted or idle DMA has no backlog.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = sat_inc(cnt_q, LIMIT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_next_o = (cnt_d == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core and a DMA/debug port.
// Core has priority; a starved DMA requester is forced through after MAX_WAIT lost cycles.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          core_req_valid,
    input  logic          core_req_we,
    input  logic [AW-1:0] core_req_addr,
    input  logic [DW-1:0] core_req_wdata,
    output logic          core_req_ready,
    output logic          core_rsp_valid,
    output logic [DW-1:0] core_rsp_rdata,
    output logic          core_stall,

    input  logic          dma_req_valid,
    input  logic          dma_req_we,
    input  logic [AW-1:0] dma_req_addr,
    input  logic [DW-1:0] dma_req_wdata,
    output logic          dma_req_ready,
    output logic          dma_rsp_valid,
    output logic [DW-1:0] dma_rsp_rdata,

    output logic          mem_wr_en,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t    state_q;
    arb_state_t    state_d;
    grant_t        grant;
    logic          starve_sat_next;

    logic          core_rsp_valid_q;
    logic          core_rsp_valid_d;
    logic [DW-1:0] core_rsp_rdata_q;
    logic [DW-1:0] core_rsp_rdata_d;
    logic          dma_rsp_valid_q;
    logic          dma_rsp_valid_d;
    logic [DW-1:0] dma_rsp_rdata_q;
    logic [DW-1:0] dma_rsp_rdata_d;

    dmem_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .inc_i      (dma_req_valid & ~dma_req_ready),
        .clr_i      ((grant == GNT_DMA) | ~dma_req_valid),
        .sat_next_o (starve_sat_next)
    );

    // Grant selection and next state; in ST_FORCE the core is locked out for one decision.
    always_comb begin
        grant   = GNT_NONE;
        state_d = state_q;
        unique case (state_q)
            ST_NORMAL: begin
                if (core_req_valid) begin
                    grant = GNT_CORE;
                end else if (dma_req_valid) begin
                    grant = GNT_DMA;
                end
                if (starve_sat_next) begin
                    state_d = ST_FORCE;
                end
            end
            ST_FORCE: begin
                if (dma_req_valid) begin
                    grant = GNT_DMA;
                end
                if ((grant == GNT_DMA) || !dma_req_valid) begin
                    state_d = ST_NORMAL;
                end
            end
            default: begin
                state_d = ST_NORMAL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign core_req_ready = (grant == GNT_CORE);
    assign dma_req_ready  = (grant == GNT_DMA);
    assign core_stall     = core_req_valid & ~core_req_ready;

    always_comb begin
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (grant)
            GNT_CORE: begin
                mem_wr_en = core_req_we;
                mem_rd_en = ~core_req_we;
                mem_addr  = core_req_addr;
                mem_wdata = core_req_wdata;
            end
            GNT_DMA: begin
                mem_wr_en = dma_req_we;
                mem_rd_en = ~dma_req_we;
                mem_addr  = dma_req_addr;
                mem_wdata = dma_req_wdata;
            end
            default: ;
        endcase
    end

    // Read data is captured in the grant cycle; stores return zero, idle cycles hold the last value.
    always_comb begin
        core_rsp_valid_d = (grant == GNT_CORE);
        core_rsp_rdata_d = core_rsp_rdata_q;
        dma_rsp_valid_d  = (grant == GNT_DMA);
        dma_rsp_rdata_d  = dma_rsp_rdata_q;
        if (grant == GNT_CORE) begin
            core_rsp_rdata_d = core_req_we ? '0 : mem_rdata;
        end
        if (grant == GNT_DMA) begin
            dma_rsp_rdata_d = dma_req_we ? '0 : mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_rsp_valid_q <= 1'b0;
            core_rsp_rdata_q <= '0;
            dma_rsp_valid_q  <= 1'b0;
            dma_rsp_rdata_q  <= '0;
        end else begin
            core_rsp_valid_q <= core_rsp_valid_d;
            core_rsp_rdata_q <= core_rsp_rdata_d;
            dma_rsp_valid_q  <= dma_rsp_valid_d;
            dma_rsp_rdata_q  <= dma_rsp_rdata_d;
        end
    end

    assign core_rsp_valid = core_rsp_valid_q;
    assign core_rsp_rdata = core_rsp_rdata_q;
    assign dma_rsp_valid  = dma_rsp_valid_q;
    assign dma_rsp_rdata  = dma_rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a word-addressed memory model on the memory port.
// Inputs change on the falling edge; combinational outputs are sampled 1 ns later, responses 1 ns after the rising edge.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk;
    logic        reset;
    logic        core_req_valid;
    logic        core_req_we;
    logic [31:0] core_req_addr;
    logic [31:0] core_req_wdata;
    logic        core_req_ready;
    logic        core_rsp_valid;
    logic [31:0] core_rsp_rdata;
    logic        core_stall;
    logic        dma_req_valid;
    logic        dma_req_we;
    logic [31:0] dma_req_addr;
    logic [31:0] dma_req_wdata;
    logic        dma_req_ready;
    logic        dma_rsp_valid;
    logic [31:0] dma_rsp_rdata;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] memModel [0:63];
    int          compared;
    int          mismatched;

    dmem_arbiter #(
        .AW       (32),
        .DW       (32),
        .MAX_WAIT (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .core_req_valid (core_req_valid),
        .core_req_we    (core_req_we),
        .core_req_addr  (core_req_addr),
        .core_req_wdata (core_req_wdata),
        .core_req_ready (core_req_ready),
        .core_rsp_valid (core_rsp_valid),
        .core_rsp_rdata (core_rsp_rdata),
        .core_stall     (core_stall),
        .dma_req_valid  (dma_req_valid),
        .dma_req_we     (dma_req_we),
        .dma_req_addr   (dma_req_addr),
        .dma_req_wdata  (dma_req_wdata),
        .dma_req_ready  (dma_req_ready),
        .dma_rsp_valid  (dma_rsp_valid),
        .dma_rsp_rdata  (dma_rsp_rdata),
        .mem_wr_en      (mem_wr_en),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory: combinational read, write on the rising edge.
    assign mem_rdata = memModel[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_wr_en) begin
            memModel[mem_addr[7:2]] <= mem_wdata;
        end
    end

    task automatic applyStimulus(
        input logic        cv,
        input logic        cwe,
        input logic [31:0] ca,
        input logic [31:0] cwd,
        input logic        dv,
        input logic        dwe,
        input logic [31:0] da,
        input logic [31:0] dwd
    );
        core_req_valid = cv;
        core_req_we    = cwe;
        core_req_addr  = ca;
        core_req_wdata = cwd;
        dma_req_valid  = dv;
        dma_req_we     = dwe;
        dma_req_addr   = da;
        dma_req_wdata  = dwd;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic idleCycle();
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic dmaStore(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, addr, data);
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_core_rsp_valid", core_rsp_valid, 1'b0);
        checkOutput("rst_core_rsp_rdata", core_rsp_rdata, 32'h0);
        checkOutput("rst_dma_rsp_valid", dma_rsp_valid, 1'b0);
        checkOutput("rst_dma_rsp_rdata", dma_rsp_rdata, 32'h0);
        checkOutput("rst_state", dut.state_q, ST_NORMAL);
        checkOutput("rst_starve", dut.u_starve.cnt_q, 4'd0);
        checkOutput("rst_mem_wr_en", mem_wr_en, 1'b0);
        reset = 1'b1;

        // Preload memory through the DMA write path.
        dmaStore(32'h0000_0020, 32'h1234_5678);
        checkOutput("pre_dma_store_rsp", dma_rsp_valid, 1'b1);
        checkOutput("pre_dma_store_rdata", dma_rsp_rdata, 32'h0);
        dmaStore(32'h0000_0000, 32'hA0A0_A0A0);
        dmaStore(32'h0000_0004, 32'hB1B1_B1B1);
        dmaStore(32'h0000_0008, 32'hC2C2_C2C2);
        idleCycle();

        // Core-only store then load.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("t1_st_ready", core_req_ready, 1'b1);
        checkOutput("t1_st_wr_en", mem_wr_en, 1'b1);
        checkOutput("t1_st_rd_en", mem_rd_en, 1'b0);
        checkOutput("t1_st_addr", mem_addr, 32'h0000_0010);
        checkOutput("t1_st_wdata", mem_wdata, 32'hDEAD_BEEF);
        checkOutput("t1_st_stall", core_stall, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("t1_st_rsp_valid", core_rsp_valid, 1'b1);
        checkOutput("t1_st_rsp_rdata", core_rsp_rdata, 32'h0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("t1_ld_ready", core_req_ready, 1'b1);
        checkOutput("t1_ld_rd_en", mem_rd_en, 1'b1);
        checkOutput("t1_ld_wr_en", mem_wr_en, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("t1_ld_rsp_valid", core_rsp_valid, 1'b1);
        checkOutput("t1_ld_rsp_rdata", core_rsp_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("t1_idle_addr", mem_addr, 32'h0);
        checkOutput("t1_idle_rd_en", mem_rd_en, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("t1_idle_rsp_valid", core_rsp_valid, 1'b0);
        checkOutput("t1_idle_rsp_hold", core_rsp_rdata, 32'hDEAD_BEEF);

        // DMA-only load.
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
        #1;
        checkOutput("t2_ready", dma_req_ready, 1'b1);
        checkOutput("t2_rd_en", mem_rd_en, 1'b1);
        checkOutput("t2_addr", mem_addr, 32'h0000_0020);
        checkOutput("t2_stall", core_stall, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("t2_rsp_valid", dma_rsp_valid, 1'b1);
        checkOutput("t2_rsp_rdata", dma_rsp_rdata, 32'h1234_5678);
        checkOutput("t2_core_rsp_valid", core_rsp_valid, 1'b0);
        idleCycle();
        checkOutput("t2_rsp_drop", dma_rsp_valid, 1'b0);

        // Both requesting continuously: DMA forced through on every 5th cycle.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
        for (int k = 0; k < 10; k++) begin
            #1;
            checkOutput($sformatf("t3_core_ready_%0d", k), core_req_ready, !(k == 4 || k == 9));
            checkOutput($sformatf("t3_dma_ready_%0d", k), dma_req_ready, (k == 4 || k == 9));
            checkOutput($sformatf("t3_stall_%0d", k), core_stall, (k == 4 || k == 9));
            checkOutput($sformatf("t3_single_%0d", k), core_req_ready & dma_req_ready, 1'b0);
            checkOutput($sformatf("t3_starve_%0d", k), dut.u_starve.cnt_q, 4'(k % 5));
            checkOutput($sformatf("t3_state_%0d", k), dut.state_q,
                        (k == 4 || k == 9) ? ST_FORCE : ST_NORMAL);
            @(negedge clk);
        end
        #1;
        checkOutput("t3_dma_rsp_rdata", dma_rsp_rdata, 32'hB1B1_B1B1);
        idleCycle();

        // DMA withdraws after two lost cycles.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
        #1;
        checkOutput("t4_ready_0", core_req_ready, 1'b1);
        checkOutput("t4_starve_0", dut.u_starve.cnt_q, 4'd0);
        @(negedge clk);
        #1;
        checkOutput("t4_starve_1", dut.u_starve.cnt_q, 4'd1);
        @(negedge clk);
        #1;
        checkOutput("t4_starve_2", dut.u_starve.cnt_q, 4'd2);
        dma_req_valid = 1'b0;
        #1;
        checkOutput("t4_ready_drop", core_req_ready, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("t4_starve_clr", dut.u_starve.cnt_q, 4'd0);
        checkOutput("t4_state", dut.state_q, ST_NORMAL);
        @(negedge clk);
        dma_req_valid = 1'b1;
        #1;
        checkOutput("t4_ready_again", core_req_ready, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("t4_ready_last", core_req_ready, 1'b1);
        checkOutput("t4_starve_last", dut.u_starve.cnt_q, 4'd1);
        checkOutput("t4_state_last", dut.state_q, ST_NORMAL);
        idleCycle();

        // Reset arrives while a core load response is pending.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("t5_ready", core_req_ready, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("t5_ready_in_reset", core_req_ready, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("t5_rsp_valid", core_rsp_valid, 1'b0);
        checkOutput("t5_rsp_rdata", core_rsp_rdata, 32'h0);
        checkOutput("t5_starve", dut.u_starve.cnt_q, 4'd0);
        checkOutput("t5_state", dut.state_q, ST_NORMAL);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("t5_post_rd_en", mem_rd_en, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("t5_post_rsp_valid", core_rsp_valid, 1'b1);
        checkOutput("t5_post_rsp_rdata", core_rsp_rdata, 32'hDEAD_BEEF);

        // Back-to-back core loads.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("t6_rsp_valid_0", core_rsp_valid, 1'b1);
        checkOutput("t6_rsp_rdata_0", core_rsp_rdata, 32'hA0A0_A0A0);
        @(negedge clk);
        core_req_addr = 32'h0000_0004;
        @(posedge clk);
        #1;
        checkOutput("t6_rsp_valid_4", core_rsp_valid, 1'b1);
        checkOutput("t6_rsp_rdata_4", core_rsp_rdata, 32'hB1B1_B1B1);
        @(negedge clk);
        core_req_addr = 32'h0000_0008;
        @(posedge clk);
        #1;
        checkOutput("t6_rsp_valid_8", core_rsp_valid, 1'b1);
        checkOutput("t6_rsp_rdata_8", core_rsp_rdata, 32'hC2C2_C2C2);
        idleCycle();
        checkOutput("t6_rsp_end", core_rsp_valid, 1'b0);
        checkOutput("t6_rsp_hold", core_rsp_rdata, 32'hC2C2_C2C2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
